// File: rtl/random_generator_pkg.sv
// Shared LFSR constants and helpers for random_generator and its scoreboards.
// Helpers work on a 64-bit container; narrower states live zero-extended in the low bits.
package random_generator_pkg;

    localparam logic [63:0] LFSR_DEFAULT_SEED = '1;

    function automatic bit lfsr_width_supported(input int width);
        return (width == 8) || (width == 16) || (width == 24) ||
               (width == 32) || (width == 64);
    endfunction

    function automatic logic [63:0] lfsr_tap_mask(input int width);
        case (width)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            24:      return 64'h0000_0000_00E1_0000;
            32:      return 64'h0000_0000_8020_0003;
            64:      return 64'hD800_0000_0000_0000;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                             input logic [63:0] mask);
        return (state >> 1) ^ (state[0] ? mask : 64'h0);
    endfunction

endpackage

// File: rtl/random_generator_lfsr_core.sv
// Right-shift Galois LFSR with one-shot seeding after reset and an advance enable.
// A zero seed is replaced by all-ones so the register can never lock up at zero.
module random_generator_lfsr_core
    import random_generator_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic             in_enable,
    input  logic [WIDTH-1:0] in_seed,
    output logic [WIDTH-1:0] lfsr
);

    localparam logic [63:0]      TAP_MASK     = lfsr_tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(LFSR_DEFAULT_SEED);

    logic seeded;

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            lfsr   <= '0;
            seeded <= 1'b0;
        end else if (!seeded) begin
            lfsr   <= (in_seed == '0) ? DEFAULT_SEED : in_seed;
            seeded <= 1'b1;
        end else if (in_enable) begin
            lfsr <= WIDTH'(lfsr_next(64'(lfsr), TAP_MASK));
        end
    end

endmodule

// File: rtl/random_generator.sv
// Bounded pseudo-random source: LFSR state scaled into the inclusive range [in_min, in_max].
// Mapping is offset = (lfsr * span) >> WIDTH, so it never exceeds span-1 and needs no divider.
module random_generator
    import random_generator_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    in_clock,
    input  logic                    in_reset,
    input  logic                    in_enable,
    input  logic signed [WIDTH-1:0] in_min,
    input  logic signed [WIDTH-1:0] in_max,
    input  logic        [WIDTH-1:0] in_seed,
    output logic signed [WIDTH-1:0] out_random
);

    generate
        if (!lfsr_width_supported(WIDTH)) begin : g_bad_width
            $error("random_generator: WIDTH must be 8, 16, 24, 32 or 64");
        end
    endgenerate

    logic [WIDTH-1:0]   lfsr;
    logic [WIDTH:0]     min_ext;
    logic [WIDTH:0]     max_ext;
    logic [WIDTH:0]     span;
    logic [2*WIDTH:0]   product;
    logic               degenerate;

    random_generator_lfsr_core #(
        .WIDTH(WIDTH)
    ) u_lfsr_core (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_enable(in_enable),
        .in_seed  (in_seed),
        .lfsr     (lfsr)
    );

    // One extra bit holds spans up to 2^WIDTH (full signed range) without wrapping.
    assign min_ext    = {in_min[WIDTH-1], in_min};
    assign max_ext    = {in_max[WIDTH-1], in_max};
    assign span       = max_ext - min_ext + {{WIDTH{1'b0}}, 1'b1};
    assign product    = {{(WIDTH+1){1'b0}}, lfsr} * {{WIDTH{1'b0}}, span};
    assign degenerate = (in_min > in_max);

    assign out_random = degenerate ? in_min
                                   : in_min + WIDTH'(product >> WIDTH);

endmodule

// File: tb/tb_random_generator.sv
// Self-checking bench for random_generator (WIDTH=32): reference model plus directed literals.
module tb_random_generator;
    import random_generator_pkg::*;

    localparam logic signed [31:0] MOST_NEG = 32'sh8000_0000;
    localparam logic signed [31:0] MOST_POS = 32'sh7FFF_FFFF;

    logic               clock;
    logic               rst_n;
    logic               enable;
    logic signed [31:0] min_v;
    logic signed [31:0] max_v;
    logic        [31:0] seed;
    logic signed [31:0] out_r;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_lfsr   = '0;
    bit          m_seeded = 1'b0;

    random_generator #(.WIDTH(32)) dut (
        .in_clock  (clock),
        .in_reset  (rst_n),
        .in_enable (enable),
        .in_min    (min_v),
        .in_max    (max_v),
        .in_seed   (seed),
        .out_random(out_r)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: value = min + floor(lfsr * count_of_values / 2^32), min when range is empty.
    function automatic logic [31:0] expect_out(input logic [31:0] l,
                                               input logic signed [31:0] mn,
                                               input logic signed [31:0] mx);
        longint      lo, hi, span;
        logic [63:0] prod;
        lo = mn;
        hi = mx;
        if (lo > hi) return mn;
        span = hi - lo + 1;
        prod = 64'(l) * 64'(span);
        return 32'(lo + longint'(prod >> 32));
    endfunction

    always @(negedge rst_n) begin
        m_lfsr   = '0;
        m_seeded = 1'b0;
    end

    always @(posedge clock) begin
        if (rst_n) begin
            if (!m_seeded) begin
                m_lfsr   = (seed == 0) ? 32'hFFFF_FFFF : seed;
                m_seeded = 1'b1;
            end else if (enable) begin
                m_lfsr = 32'(lfsr_next(64'(m_lfsr), lfsr_tap_mask(32)));
            end
        end
    end

    always @(negedge clock) begin
        logic [31:0] e;
        e = expect_out(m_lfsr, min_v, max_v);
        n_cmp++;
        if (out_r !== e) begin
            n_bad++;
            $display("FAIL model t=%0t: out_random=%h expected=%h (min=%0d max=%0d)",
                     $time, out_r, e, min_v, max_v);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic set_range(input logic signed [31:0] mn, input logic signed [31:0] mx);
        min_v = mn;
        max_v = mx;
        #1;
    endtask

    task automatic sweep(input logic signed [31:0] mn, input logic signed [31:0] mx,
                         input bit want_cover);
        bit hit [64];
        int missing;
        int out_of_range;
        longint idx;
        foreach (hit[i]) hit[i] = 1'b0;
        out_of_range = 0;
        set_range(mn, mx);
        enable = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            tick();
            if (out_r < mn || out_r > mx) out_of_range++;
            else begin
                idx = longint'(out_r) - longint'(mn);
                if (idx < 64) hit[idx] = 1'b1;
            end
        end
        check("bounds", 32'(out_of_range), 32'd0);
        if (want_cover) begin
            missing = 0;
            for (longint v = mn; v <= mx; v++)
                if (!hit[v - mn]) missing++;
            check("cover", 32'(missing), 32'd0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        min_v  = 0;
        max_v  = 5;
        seed   = 32'd16;

        // Reset and seed 16
        tick();
        tick();
        check("reset_out", out_r, 32'd0);
        rst_n = 1'b1;
        tick();
        check("seed_out", out_r, 32'd0);
        set_range(MOST_NEG, MOST_POS);
        check("seed_lfsr", out_r, 32'h8000_0010);

        // Advance, hold, resume: lfsr 8,4,2,(hold),1,80200003
        enable = 1'b1;
        tick(); check("step1", out_r, 32'h8000_0008);
        tick(); check("step2", out_r, 32'h8000_0004);
        tick(); check("step3", out_r, 32'h8000_0002);
        enable = 1'b0;
        tick(); check("hold1", out_r, 32'h8000_0002);
        tick(); check("hold2", out_r, 32'h8000_0002);
        enable = 1'b1;
        tick(); check("step4", out_r, 32'h8000_0001);
        tick(); check("step5", out_r, 32'h0020_0003);
        enable = 1'b0;
        set_range(0, 5);
        check("step5_small", out_r, 32'd3);

        // Zero seed falls back to all-ones
        rst_n = 1'b0;
        seed  = 32'd0;
        #1;
        check("reset_async0", out_r, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("zero_seed", out_r, 32'd5);
        set_range(MOST_NEG, MOST_POS);
        check("zero_seed_lfsr", out_r, 32'h7FFF_FFFF);
        seed = 32'd16;
        tick();
        check("seed_ignored", out_r, 32'h7FFF_FFFF);

        // Empty and single-value ranges
        enable = 1'b1;
        set_range(7, 3);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("degenerate", out_r, 32'd7);
        end
        set_range(-4, -4);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("single", out_r, 32'hFFFF_FFFC);
        end

        sweep(-20, -10, 1'b1);
        sweep(-20, 2, 1'b1);
        sweep(20, 26, 1'b1);
        sweep(-20, 0, 1'b1);
        sweep(0, 5, 1'b1);
        sweep(MOST_NEG, MOST_POS, 1'b0);

        // Asynchronous reset mid-run, then restart from seed 16
        set_range(-20, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", out_r, 32'hFFFF_FFEC);
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        set_range(MOST_NEG, MOST_POS);
        check("restart_seed", out_r, 32'h8000_0010);
        enable = 1'b1;
        tick(); check("restart1", out_r, 32'h8000_0008);
        tick(); check("restart2", out_r, 32'h8000_0004);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
